// File: rtl/sdft_sample_scheduler.sv
// Sample-ingest scheduler for the sliding-DFT bin engine.
// Buffers samples in a small FIFO, keeps the last FFT_SIZE samples in a
// circular history RAM and, per sample, presents (newest, oldest) and
// launches one bin sweep, waiting for sweep_done before the next launch.
module sdft_sample_scheduler #(
  parameter int WORD_WIDTH = 16,
  parameter int FFT_SIZE   = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,          // async, active low
  input  logic                  s_valid,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  sweep_done,
  output logic                  start_compute,
  output logic [WORD_WIDTH-1:0] SAMPLE,
  output logic [WORD_WIDTH-1:0] OLDEST_SAMPLE,
  output logic                  busy,
  output logic                  spectrum_valid,
  output logic                  frame_tick,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int PW = $clog2(FFT_SIZE);    // history pointer width
  localparam int FW = PW + 1;              // fill counter width (holds FFT_SIZE)
  localparam int QW = $clog2(FIFO_DEPTH);  // FIFO index width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------
  // Input FIFO: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [QW:0]           fifo_wr_q, fifo_rd_q;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;
  logic [WORD_WIDTH-1:0] fifo_head;

  assign fifo_empty = (fifo_wr_q == fifo_rd_q);
  assign fifo_full  = (fifo_wr_q[QW] != fifo_rd_q[QW]) &&
                      (fifo_wr_q[QW-1:0] == fifo_rd_q[QW-1:0]);
  assign fifo_push  = s_valid && !fifo_full;
  // The head is consumed only on the IDLE->FETCH edge.
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem[fifo_rd_q[QW-1:0]];
  assign s_ready    = !fifo_full;

  // FIFO pointer update; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
    end else begin
      if (fifo_push) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wr_q[QW-1:0]] <= s_data;
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps it set.
  logic overrun_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    overrun_q <= 1'b0;
    else if (s_valid && fifo_full) overrun_q <= 1'b1;
    else if (overrun_clr)          overrun_q <= 1'b0;
  end
  assign overrun = overrun_q;

  // ---------------------------------------------------------------------
  // History RAM: one write port, one synchronous read port. The slot at
  // wr_ptr holds the oldest sample; it is read on IDLE->FETCH and only
  // overwritten on the LAUNCH exit edge, so read and write never collide.
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] hist_mem [FFT_SIZE];
  logic [WORD_WIDTH-1:0] hist_rd_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [FW-1:0]         fill_q;
  logic                  fill_full;
  logic [WORD_WIDTH-1:0] sample_q, oldest_q;

  assign fill_full = (fill_q == FW'(FFT_SIZE));

  // History write of the current sample and synchronous read of the oldest.
  always_ff @(posedge clk) begin
    if (state_q == ST_LAUNCH) hist_mem[wr_ptr_q] <= sample_q;
    if (fifo_pop)             hist_rd_q <= hist_mem[wr_ptr_q];
  end

  // Write pointer wraps naturally (power-of-two depth); fill saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (state_q == ST_LAUNCH) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (!fill_full) fill_q <= fill_q + 1'b1;
    end
  end

  // Sample pair registers; held from FETCH until the next IDLE->FETCH.
  // Until the window has filled the RAM slot is stale, so present zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q <= '0;
      oldest_q <= '0;
    end else begin
      if (fifo_pop)              sample_q <= fifo_head;
      if (state_q == ST_FETCH)   oldest_q <= fill_full ? hist_rd_q : '0;
    end
  end
  assign SAMPLE        = sample_q;
  assign OLDEST_SAMPLE = oldest_q;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and decoded outputs; sweep_done only matters in WAIT.
  always_comb begin
    state_d       = state_q;
    start_compute = 1'b0;
    busy          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (!fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH:  state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        start_compute = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (sweep_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame completion: a sweep that finishes over a full window ticks once
  // and latches spectrum_valid.
  logic frame_done;
  logic frame_tick_q, spec_valid_q;
  assign frame_done = (state_q == ST_WAIT) && sweep_done && fill_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick_q <= 1'b0;
      spec_valid_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_done;
      if (frame_done) spec_valid_q <= 1'b1;
    end
  end
  assign frame_tick     = frame_tick_q;
  assign spectrum_valid = spec_valid_q;

endmodule

// File: tb/tb_sdft_sample_scheduler.sv
// Self-checking bench for sdft_sample_scheduler (FFT_SIZE=8, FIFO_DEPTH=4).
// The reference model keeps every accepted sample in order; the n-th launch
// must present sample n and, once n >= FFT_SIZE, sample n-FFT_SIZE.
`timescale 1ns/1ps
module tb_sdft_sample_scheduler;
  localparam int W = 16;
  localparam int N = 8;
  localparam int D = 4;

  logic         clk, rst_n;
  logic         s_valid, s_ready;
  logic [W-1:0] s_data;
  logic         sweep_done, start_compute, busy;
  logic [W-1:0] SAMPLE, OLDEST_SAMPLE;
  logic         spectrum_valid, frame_tick, overrun, overrun_clr;
  logic         eng_done, tb_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] acc[$];
  int           n_launch = 0;
  int           frame_cnt = 0;
  bit           prev_sc = 0;
  bit           auto_done = 1;
  int           eng_cnt = 0;

  assign sweep_done = eng_done | tb_done;

  sdft_sample_scheduler #(.WORD_WIDTH(W), .FFT_SIZE(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .sweep_done(sweep_done), .start_compute(start_compute), .SAMPLE(SAMPLE),
    .OLDEST_SAMPLE(OLDEST_SAMPLE), .busy(busy), .spectrum_valid(spectrum_valid),
    .frame_tick(frame_tick), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Bin engine model: sweep_done 10 cycles after start_compute.
  initial begin
    eng_done = 0;
    forever begin
      @(posedge clk); #1;
      eng_done = 0;
      if (!rst_n) eng_cnt = 0;
      else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1;
      end else if (start_compute && auto_done) eng_cnt = 10;
    end
  end

  // Monitor: record accepted samples, check each launch against the model.
  initial begin
    logic [W-1:0] exp_s, exp_o;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (s_valid && s_ready) acc.push_back(s_data);
        if (start_compute) begin
          checks++;
          if (prev_sc) begin
            errors++;
            $display("FAIL start_pulse_width: start_compute high on consecutive cycles, required single cycle");
          end
          checks++;
          if (n_launch >= acc.size()) begin
            errors++;
            $display("FAIL launch_unexpected: launch %0d with only %0d samples accepted", n_launch, acc.size());
          end else begin
            exp_s = acc[n_launch];
            exp_o = (n_launch >= N) ? acc[n_launch-N] : '0;
            if (SAMPLE !== exp_s || OLDEST_SAMPLE !== exp_o) begin
              errors++;
              $display("FAIL launch_pair[%0d]: got SAMPLE=%0d OLDEST=%0d, required SAMPLE=%0d OLDEST=%0d",
                       n_launch, SAMPLE, OLDEST_SAMPLE, exp_s, exp_o);
            end
          end
          n_launch++;
        end
        if (frame_tick) frame_cnt++;
        prev_sc = start_compute;
      end else prev_sc = 0;
    end
  end

  task automatic apply_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    acc.delete();
    n_launch  = 0;
    frame_cnt = 0;
    #1 rst_n = 1;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic push(input logic [W-1:0] d);
    int t = 0;
    s_valid = 1; s_data = d;
    @(negedge clk);
    while (!s_ready && t < 500) begin t++; @(negedge clk); end
    if (!s_ready) begin
      errors++;
      $display("FAIL push_timeout: s_ready=0 after 500 cycles, required 1");
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while (!(n_launch == acc.size() && !busy) && t < 3000) begin t++; @(negedge clk); end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: launches=%0d accepted=%0d busy=%0b, required all launched and idle",
               n_launch, acc.size(), busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_launches(input int n);
    int t = 0;
    while (n_launch < n && t < 2000) begin t++; @(negedge clk); end
    checks++;
    if (n_launch < n) begin
      errors++;
      $display("FAIL launch_timeout: launches=%0d, required %0d", n_launch, n);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (busy !== 0 || start_compute !== 0 || SAMPLE !== 0 || OLDEST_SAMPLE !== 0 ||
        s_ready !== 1 || spectrum_valid !== 0 || frame_tick !== 0 || overrun !== 0) begin
      errors++;
      $display("FAIL %s: busy=%b start=%b SAMPLE=%0d OLDEST=%0d s_ready=%b sv=%b ft=%b ovr=%b, required 0 0 0 0 1 0 0 0",
               nm, busy, start_compute, SAMPLE, OLDEST_SAMPLE, s_ready, spectrum_valid, frame_tick, overrun);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    check_reset_outputs("reset_state");
    apply_reset();
    @(negedge clk);
    check_reset_outputs("after_reset_release");
    @(posedge clk); #1;
  endtask

  task automatic test_warmup();
    apply_reset();
    for (int k = 1; k <= N; k++) push(W'(k));
    wait_launches(N);
    checks++;
    if (spectrum_valid !== 0 || frame_cnt != 0) begin
      errors++;
      $display("FAIL warmup_early: spectrum_valid=%b frame_ticks=%0d, required 0 0", spectrum_valid, frame_cnt);
    end
    drain();
    checks++;
    if (n_launch != N || frame_cnt != 1 || spectrum_valid !== 1) begin
      errors++;
      $display("FAIL warmup_done: launches=%0d frame_ticks=%0d sv=%b, required %0d 1 1",
               n_launch, frame_cnt, spectrum_valid, N);
    end
  endtask

  task automatic test_steady_wrap();
    apply_reset();
    for (int k = 1; k <= 20; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 push(W'(k));
    end
    drain();
    checks++;
    if (n_launch != 20 || frame_cnt != 13 || spectrum_valid !== 1) begin
      errors++;
      $display("FAIL steady_wrap: launches=%0d frame_ticks=%0d sv=%b, required 20 13 1",
               n_launch, frame_cnt, spectrum_valid);
    end
  endtask

  task automatic test_stray_done();
    int f0 = frame_cnt;
    tb_done = 1;
    @(posedge clk); #1;
    tb_done = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || frame_tick !== 0) begin
      errors++;
      $display("FAIL stray_done: busy=%b frame_tick=%b, required 0 0", busy, frame_tick);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (frame_cnt != f0) begin
      errors++;
      $display("FAIL stray_frame: frame_ticks=%0d, required %0d", frame_cnt, f0);
    end
  endtask

  task automatic test_latency();
    int t = 0;
    bit seen = 0;
    s_valid = 1; s_data = W'($urandom);
    @(posedge clk); #1;                 // handshake edge E0
    s_valid = 0;
    @(negedge clk);                     // between E0 and E1
    checks++;
    if (start_compute !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL lat_e0: start=%b busy=%b, required 0 0", start_compute, busy);
    end
    @(negedge clk);                     // between E1 and E2
    checks++;
    if (start_compute !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL lat_e1: start=%b busy=%b, required 0 1", start_compute, busy);
    end
    @(negedge clk);                     // between E2 and E3
    checks++;
    if (start_compute !== 1) begin
      errors++;
      $display("FAIL lat_e2: start=%b, required 1", start_compute);
    end
    @(negedge clk);
    checks++;
    if (start_compute !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL lat_e3: start=%b busy=%b, required 0 1", start_compute, busy);
    end
    while (!seen && t < 50) begin
      if (sweep_done) seen = 1;
      else if (busy !== 1) begin
        errors++;
        $display("FAIL lat_busy: busy=%b before sweep_done, required 1", busy);
      end
      t++;
      @(negedge clk);
    end
    checks++;
    if (!seen || busy !== 0) begin
      errors++;
      $display("FAIL lat_done: seen_done=%b busy=%b, required 1 0", seen, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    bit saw_full = 0;
    apply_reset();
    auto_done = 0;
    s_valid = 1;
    for (int i = 0; i < 12; i++) begin
      s_data = W'($urandom);
      @(negedge clk);
      if (!s_ready) saw_full = 1;
      @(posedge clk); #1;
    end
    s_valid = 0;
    checks++;
    if (!saw_full || overrun !== 1 || acc.size() != D + 1) begin
      errors++;
      $display("FAIL overrun_set: saw_full=%b overrun=%b accepted=%0d, required 1 1 %0d",
               saw_full, overrun, acc.size(), D + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
    s_valid = 1; overrun_clr = 1; s_data = W'($urandom);
    @(posedge clk); #1;
    s_valid = 0;
    checks++;
    if (overrun !== 1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun=%b, required 1", overrun);
    end
    @(posedge clk); #1;
    overrun_clr = 0;
    checks++;
    if (overrun !== 0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
    auto_done = 1;
    tb_done = 1;
    @(posedge clk); #1;
    tb_done = 0;
    drain();
    checks++;
    if (n_launch != D + 1) begin
      errors++;
      $display("FAIL overrun_drain: launches=%0d, required %0d", n_launch, D + 1);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    for (int k = 0; k < 5; k++) push(W'($urandom));
    wait_launches(5);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1 || SAMPLE === 0) begin
      errors++;
      $display("FAIL mid_wait_pre: busy=%b SAMPLE=%0d, required busy 1 and nonzero sample", busy, SAMPLE);
    end
    #1 rst_n = 0;
    #1 check_reset_outputs("reset_mid_wait");
    apply_reset();
    for (int k = 0; k < N - 1; k++) push(W'($urandom_range(1, 65535)));
    drain();
    checks++;
    if (frame_cnt != 0 || spectrum_valid !== 0) begin
      errors++;
      $display("FAIL refill_early: frame_ticks=%0d sv=%b, required 0 0", frame_cnt, spectrum_valid);
    end
    push(W'($urandom));
    drain();
    checks++;
    if (frame_cnt != 1 || spectrum_valid !== 1) begin
      errors++;
      $display("FAIL refill_done: frame_ticks=%0d sv=%b, required 1 1", frame_cnt, spectrum_valid);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 25)) @(posedge clk);
      #1 push(W'($urandom));
    end
    drain();
    checks++;
    if (n_launch != 30 || frame_cnt != 30 - N + 1 || overrun !== 0) begin
      errors++;
      $display("FAIL random_stream: launches=%0d frame_ticks=%0d overrun=%b, required 30 %0d 0",
               n_launch, frame_cnt, overrun, 30 - N + 1);
    end
  endtask

  initial begin
    rst_n = 0; s_valid = 0; s_data = '0; overrun_clr = 0; tb_done = 0;
    test_reset();
    test_warmup();
    test_steady_wrap();
    test_stray_done();
    test_latency();
    test_overrun();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
